// File: rtl/rans_pkg.sv
// Shared definitions for the rANS encoder back-end: lane index sizing,
// flush state encoding and the default encoded word width.
package rans_pkg;

    // Default encoded word width, shared with the rANS encoder lanes.
    localparam int RANS_DATA_WIDTH = 8;

    // Flush/drain state machine encoding.
    typedef enum logic {
        FL_IDLE  = 1'b0,
        FL_DRAIN = 1'b1
    } flush_state_e;

    // Width of a lane index; never narrower than one bit.
    function automatic int LANE_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rans_lane_fifo.sv
// Small synchronous per-lane FIFO with registered occupancy count.
// A write accepted in cycle t is readable (rd_data) from cycle t+1.
// Writes to a full FIFO are accepted only when a read happens in the same cycle.
module rans_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_ok    = rd_en && !empty;
        wr_ok    = wr_en && (!full || rd_ok);
        if (wr_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end

    // State registers; reset empties the FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rans_lane_collector.sv
// Collects words from NUM_LANES interleaved rANS encoder lanes into one
// lane-tagged output stream.
// Handshake: a lane word is taken when lane_valid_i[i] is high and its FIFO
// has room (lane_ready_o[i]); the output word transfers on a cycle where
// valid_o && ready_i, and data_o/lane_o/valid_o hold stable while
// valid_o && !ready_i.
// STRICT_RR=1 visits lanes in fixed order and stalls on an empty lane;
// STRICT_RR=0, or any cycle during a flush, skips empty lanes.
module rans_lane_collector
    import rans_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = RANS_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter bit STRICT_RR  = 1'b1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_LANES-1:0]              lane_valid_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]   lane_data_i,
    output logic [NUM_LANES-1:0]              lane_ready_o,
    output logic                              valid_o,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic [LANE_IDX_W(NUM_LANES)-1:0]  lane_o,
    input  logic                              ready_i,
    input  logic                              flush_i,
    output logic                              done_o,
    output logic                              overflow_o
);

    localparam int LW  = LANE_IDX_W(NUM_LANES);
    localparam int LWP = LW + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LWP-1:0] LANES_W = LWP'(NUM_LANES);

    logic [NUM_LANES-1:0]  fifo_full;
    logic [NUM_LANES-1:0]  fifo_empty;
    logic [NUM_LANES-1:0]  fifo_wr;
    logic [NUM_LANES-1:0]  fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_rdata [NUM_LANES];
    logic [CW-1:0]         fifo_count [NUM_LANES];

    flush_state_e          state_q, state_d;
    logic [LW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [LW-1:0]         lane_q, lane_d;
    logic                  done_q, done_d;
    logic                  overflow_q, overflow_d;

    logic                  flush_active;
    logic                  load_en;
    logic                  all_empty;
    logic                  drain_exit;
    logic                  sel_found;
    logic [LW-1:0]         sel_idx;
    logic [LW-1:0]         rr_next;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            rans_lane_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (DATA_WIDTH)
            ) u_fifo (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .wr_en   (fifo_wr[g]),
                .wr_data (lane_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
                .rd_en   (fifo_rd[g]),
                .rd_data (fifo_rdata[g]),
                .count   (fifo_count[g]),
                .full    (fifo_full[g]),
                .empty   (fifo_empty[g])
            );
        end
    endgenerate

    assign flush_active = (state_q == FL_DRAIN);
    assign load_en      = !valid_q || ready_i;
    assign lane_ready_o = ~fifo_full;
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign lane_o       = lane_q;
    assign done_o       = done_q;
    assign overflow_o   = overflow_q;

    // Drain is complete once every lane FIFO holds nothing.
    always_comb begin
        all_empty = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fifo_count[i] != '0) begin
                all_empty = 1'b0;
            end
        end
    end

    // Flush FSM: drain until FIFOs and output register are clear, then pulse done.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        drain_exit = 1'b0;
        case (state_q)
            FL_IDLE: begin
                if (flush_i) begin
                    state_d = FL_DRAIN;
                end
            end
            FL_DRAIN: begin
                if (all_empty && (!valid_q || ready_i)) begin
                    drain_exit = 1'b1;
                    done_d     = 1'b1;
                    state_d    = FL_IDLE;
                end
            end
            default: state_d = FL_IDLE;
        endcase
    end

    // Lane selection: fixed candidate in strict mode, else first non-empty from rr_ptr with wrap.
    always_comb begin
        logic [LWP-1:0] idx_w;
        logic [LWP-1:0] nxt_w;
        sel_found = 1'b0;
        sel_idx   = rr_ptr_q;
        idx_w     = '0;
        if (STRICT_RR && !flush_active) begin
            sel_found = !fifo_empty[rr_ptr_q];
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                idx_w = {1'b0, rr_ptr_q} + LWP'(k);
                if (idx_w >= LANES_W) begin
                    idx_w = idx_w - LANES_W;
                end
                if (!sel_found && !fifo_empty[idx_w[LW-1:0]]) begin
                    sel_found = 1'b1;
                    sel_idx   = idx_w[LW-1:0];
                end
            end
        end
        nxt_w = {1'b0, sel_idx} + LWP'(1);
        if (nxt_w >= LANES_W) begin
            nxt_w = '0;
        end
        rr_next = nxt_w[LW-1:0];
    end

    // Output register load, FIFO pop and round-robin pointer advance.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        lane_d   = lane_q;
        rr_ptr_d = rr_ptr_q;
        fifo_rd  = '0;
        if (load_en) begin
            valid_d = sel_found;
            if (sel_found) begin
                data_d           = fifo_rdata[sel_idx];
                lane_d           = sel_idx;
                fifo_rd[sel_idx] = 1'b1;
                rr_ptr_d         = rr_next;
            end
        end
        if (drain_exit) begin
            rr_ptr_d = '0;
        end
    end

    // Lane writes: a full lane only takes a word when it is popped this cycle; otherwise it is lost.
    always_comb begin
        fifo_wr    = lane_valid_i & (~fifo_full | fifo_rd);
        overflow_d = overflow_q | (|(lane_valid_i & fifo_full & ~fifo_rd));
    end

    // Control and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= FL_IDLE;
            rr_ptr_q   <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            lane_q     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            lane_q     <= lane_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: doc/rans_lane_collector.md
Name: rans_lane_collector

Overview:
- Parametrised successor to the fixed 4-lane rANS output mux.
- Collects encoded bytes from NUM_LANES interleaved rANS encoder lanes, all on a single clock with no gated clocks.
- Buffers each lane in a small FIFO and emits one byte stream with valid/ready backpressure, tagged with the lane index.
- Supports strict round-robin order (deterministic interleaved decode) or skip-empty order, plus a flush/drain handshake at end of block.

Parameters:
- NUM_LANES, 4, number of encoder lanes; must be ≥2.
- DATA_WIDTH, 8, width of each encoded word.
- FIFO_DEPTH, 4, per-lane FIFO entries; power of two, ≥2.
- STRICT_RR, 1, 1 = strict round-robin (stall on an empty lane); 0 = skip empty lanes.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- lane_valid_i  in  NUM_LANES  bit i = lane i presents a word this cycle.
- lane_data_i  in  NUM_LANES*DATA_WIDTH  lane i word at [i*DATA_WIDTH +: DATA_WIDTH].
- lane_ready_o  out  NUM_LANES  bit i = lane i FIFO not full.
- valid_o  out  1  output word valid.
- data_o  out  DATA_WIDTH  output word.
- lane_o  out  $clog2(NUM_LANES)  source lane of data_o.
- ready_i  in  1  downstream accepts the word when valid_o && ready_i.
- flush_i  in  1  single-cycle pulse: drain all lanes.
- done_o  out  1  single-cycle pulse: flush complete.
- overflow_o  out  1  sticky: a lane word was dropped.

Behaviour:
- Reset (async, rst_i=1): FIFOs emptied, rr_ptr=0, flush_active=0; all outputs 0 except lane_ready_o, which is all ones.
- Lane write: lane_valid_i[i] writes FIFO i when it is not full. Write in cycle t is poppable in t+1.
- lane_ready_o[i] = !full[i], taken from registered count. It deasserts at full even if a pop happens the same cycle.
- Write to a full FIFO with no same-cycle pop: word dropped, overflow_o←1 until reset.
- Write and pop on a full FIFO in the same cycle: write accepted, count unchanged.
- Output register:
  - Loads when !valid_o || ready_i. Otherwise data_o, lane_o and valid_o hold stable.
  - First-word latency: write at cycle t → valid_o at t+2 when the pointer is already at that lane. No bypass path.
  - Throughput: one word per cycle with ready_i=1 and data available.
- Selection with STRICT_RR=1:
  - Candidate is rr_ptr.
  - If FIFO[rr_ptr] is non-empty: pop it, load the output, rr_ptr←(rr_ptr+1) mod NUM_LANES.
  - If empty and flush_active=0: no load; valid_o goes or stays 0 once the current word is accepted.
  - If empty and flush_active=1: treated as skip mode for that cycle.
- Selection with STRICT_RR=0 (or during flush):
  - Scan from rr_ptr upward with wrap; pick the first non-empty lane j.
  - Pop j, load the output, rr_ptr←(j+1) mod NUM_LANES.
  - No non-empty lane: no load.
- rr_ptr wrap: NUM_LANES need not be a power of two; the wrap is an explicit compare.
- Flush state machine:
  - IDLE: flush_i → DRAIN (flush_active=1).
  - DRAIN: flush_i is ignored; lane writes are still accepted.
  - DRAIN exits when all FIFOs are empty and (valid_o=0, or valid_o && ready_i this cycle). Next cycle: done_o=1 for one cycle, rr_ptr←0, state←IDLE.
  - flush_i with everything already empty: done_o two cycles after flush_i.
- Simultaneous events:
  - flush_i in the same cycle as a pop: the pop proceeds normally.
  - rst_i wins over everything.
- Reset mid-operation: buffered words are discarded. No partial word appears after release.

Decomposition:
- Shared package rans_pkg:
  - LANE_IDX_W(n) as a $clog2 helper function.
  - Flush state enum {FL_IDLE, FL_DRAIN}.
  - Default DATA_WIDTH=8 constant shared with the rans encoder.
- Sub-module rans_lane_fifo:
  - Synchronous FIFO, DEPTH/WIDTH parameters, async active-high reset.
  - Ports: wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Instantiated NUM_LANES times in a generate loop.
- Arbitration, output register and flush FSM live in the top of this block.

Test Plan:
1. Defaults, ready_i=1. At cycle 0 lanes 0..3 write 0x10,0x21,0x32,0x43 → valid_o from cycle 2; data_o 10,21,32,43 on consecutive cycles; lane_o 0,1,2,3.
2. STRICT_RR=1. Only lane 1 writes 0xAA → valid_o stays 0 for 10 cycles. Then lane 0 writes 0x55 → output 55 (lane 0), then AA (lane 1).
3. ready_i=0. Lane 0 writes 0x01..0x06 on six cycles; lanes 1..3 idle.
   - Output holds 0x01 stable with valid_o=1.
   - FIFO holds 0x02..0x05; lane_ready_o[0]=0 after the fifth write.
   - Sixth write is dropped → overflow_o=1, and stays 1 after ready_i=1.
4. STRICT_RR=1. Lanes 0 and 2 write 0xC0 and 0xC2, then flush_i → outputs C0 (lane 0) and C2 (lane 2) with lanes 1 and 3 skipped. done_o pulses once, the cycle after C2 is accepted. A subsequent write on lane 0 outputs with lane_o=0.
5. STRICT_RR=0, rr_ptr=0. Only lane 3 writes 0x7F → valid_o two cycles later, data_o=0x7F, lane_o=3. The next word taken is from lane 0 when all lanes are non-empty.
6. Lanes hold 3 words in total and valid_o=1; assert rst_i asynchronously mid-cycle → valid_o=0 and overflow_o=0 immediately. After release, no output appears for 5 idle cycles and lane_ready_o=all ones.
